// File: rtl/snake_dir_queue_ctrl_if.sv
// Keyboard/step inputs and game-control outputs of snake_dir_queue_ctrl.
// The master side is the keyboard/engine environment; the slave side is the controller.
interface snake_dir_queue_ctrl_if #(
  parameter int N_PLAYERS = 1
);
  logic [7:0]             key;
  logic                   key_pressed;
  logic                   step;
  logic [2*N_PLAYERS-1:0] snake_dir;
  logic                   start;
  logic                   pause;
  logic                   running;
  logic [N_PLAYERS-1:0]   key_drop;

  modport master (
    output key, key_pressed, step,
    input  snake_dir, start, pause, running, key_drop
  );

  modport slave (
    input  key, key_pressed, step,
    output snake_dir, start, pause, running, key_drop
  );
endinterface

// File: rtl/snake_dir_queue_ctrl.sv
// Keyboard-to-snake control: start/pause FSM plus one direction FIFO per player,
// popped once per game step, rejecting duplicate and 180-degree reversal requests.
module snake_dir_queue_ctrl #(
  parameter int         N_PLAYERS = 1,
  parameter int         DEPTH     = 4,
  parameter logic [1:0] DIR_RESET = 2'd0,
  parameter logic [1:0] DIR_START = 2'd1,
  parameter logic [7:0] P2_UP     = 8'h75,
  parameter logic [7:0] P2_RIGHT  = 8'h74,
  parameter logic [7:0] P2_DOWN   = 8'h72,
  parameter logic [7:0] P2_LEFT   = 8'h6B
) (
  input logic                  clk,
  input logic                  rst_n,
  snake_dir_queue_ctrl_if.slave bus
);

  // PS/2 set-2 make codes for player 1 and the global keys.
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED
  } state_t;

  state_t r_state, w_state_next;
  logic   r_start, r_pause;
  logic   w_start_next, w_pause_next;
  logic   w_enter, w_space, w_run;

  logic [2*N_PLAYERS-1:0] w_snake_dir;
  logic [N_PLAYERS-1:0]   w_key_drop;

  assign w_enter = bus.key_pressed && (bus.key == KEY_ENTER);
  assign w_space = bus.key_pressed && (bus.key == KEY_SPACE);
  assign w_run   = (r_state == S_RUN);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_start_next = 1'b0;
    w_pause_next = 1'b0;
    if (w_enter) begin
      w_state_next = S_RUN;
      w_start_next = 1'b1;
    end else if (w_space) begin
      case (r_state)
        S_RUN: begin
          w_state_next = S_PAUSED;
          w_pause_next = 1'b1;
        end
        S_PAUSED: begin
          w_state_next = S_RUN;
          w_pause_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_pause <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_start <= w_start_next;
      r_pause <= w_pause_next;
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    localparam logic [7:0] K_UP    = (p == 0) ? KEY_W : P2_UP;
    localparam logic [7:0] K_RIGHT = (p == 0) ? KEY_D : P2_RIGHT;
    localparam logic [7:0] K_DOWN  = (p == 0) ? KEY_S : P2_DOWN;
    localparam logic [7:0] K_LEFT  = (p == 0) ? KEY_A : P2_LEFT;

    logic [1:0]  r_dir;
    logic [1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0] r_count;
    logic        r_drop;

    logic        w_hit, w_dir_key, w_pop, w_push, w_drop, w_full, w_empty;
    logic [1:0]  w_new_dir, w_ref;

    always_comb begin
      w_hit     = 1'b1;
      w_new_dir = 2'd0;
      case (bus.key)
        K_UP:    w_new_dir = 2'd0;
        K_RIGHT: w_new_dir = 2'd1;
        K_DOWN:  w_new_dir = 2'd2;
        K_LEFT:  w_new_dir = 2'd3;
        default: w_hit = 1'b0;
      endcase
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PW+1)'(DEPTH));
    // Legality is judged against the last queued request, not the applied one.
    assign w_ref     = w_empty ? r_dir : r_mem[r_wr_ptr - PW'(1)];
    assign w_dir_key = bus.key_pressed && w_run && w_hit;
    assign w_pop     = bus.step && w_run && !w_empty && !w_enter;
    assign w_drop    = w_dir_key && ((w_new_dir == w_ref) ||
                                     (w_new_dir == (w_ref ^ 2'b10)) ||
                                     (w_full && !w_pop));
    assign w_push    = w_dir_key && !w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dir    <= DIR_RESET;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_drop   <= 1'b0;
      end else begin
        r_drop <= w_drop;
        if (w_enter) begin
          r_dir    <= DIR_START;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_pop) begin
            r_dir    <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + PW'(1);
          end
          if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
          if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
          else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
        end
      end
    end

    // NOTE: FIFO storage has no reset; the count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_new_dir;
    end

    assign w_snake_dir[2*p +: 2] = r_dir;
    assign w_key_drop[p]         = r_drop;
  end

  assign bus.snake_dir = w_snake_dir;
  assign bus.key_drop  = w_key_drop;
  assign bus.start     = r_start;
  assign bus.pause     = r_pause;
  assign bus.running   = w_run;

endmodule

// File: tb/tb_snake_dir_queue_ctrl.sv
// Random-stimulus scoreboard bench: a one-player and a two-player controller share inputs
// and are checked against a queue-based reference model of the game-control rules.
module tb_snake_dir_queue_ctrl;

  localparam int         DEPTH     = 4;
  localparam logic [1:0] DIR_RESET = 2'd0;
  localparam logic [1:0] DIR_START = 2'd1;
  localparam logic [7:0] K_ENTER   = 8'h5A;
  localparam logic [7:0] K_SPACE   = 8'h29;
  localparam int         N_CYCLES  = 3000;
  localparam int         RST_AT    = 1700;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snake_dir_queue_ctrl_if #(.N_PLAYERS(1)) if1 ();
  snake_dir_queue_ctrl_if #(.N_PLAYERS(2)) if2 ();

  snake_dir_queue_ctrl #(.N_PLAYERS(1), .DEPTH(DEPTH), .DIR_RESET(DIR_RESET), .DIR_START(DIR_START))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  snake_dir_queue_ctrl #(.N_PLAYERS(2), .DEPTH(DEPTH), .DIR_RESET(DIR_RESET), .DIR_START(DIR_START))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    logic [3:0] dir;
    logic       start;
    logic       pause;
    logic       running;
    logic [1:0] drop;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: 0 idle, 1 run, 2 paused; per-player pending direction queues.
  int         m_state;
  logic [1:0] m_dir [2];
  logic [1:0] m_q   [2][$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_dir(input logic [7:0] k, input int p);
    logic [7:0] codes [4];
    int         res;
    if (p == 0) codes = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
    else        codes = '{8'h75, 8'h74, 8'h72, 8'h6B};
    res = -1;
    for (int i = 0; i < 4; i++) if (k == codes[i]) res = i;
    return res;
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int p = 0; p < 2; p++) begin
      m_dir[p] = DIR_RESET;
      m_q[p].delete();
    end
  endtask

  task automatic model_step(input logic kp, input logic [7:0] k, input logic st);
    exp_t e;
    e.start = 1'b0;
    e.pause = 1'b0;
    e.drop  = 2'b00;
    if (kp && k == K_ENTER) begin
      e.start = 1'b1;
      m_state = 1;
      for (int p = 0; p < 2; p++) begin
        m_dir[p] = DIR_START;
        m_q[p].delete();
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        int         d;
        bit         pop, push;
        logic [1:0] r, nd;
        d    = key_dir(k, p);
        pop  = st && (m_state == 1) && (m_q[p].size() > 0);
        push = 1'b0;
        nd   = 2'(d);
        if (kp && (m_state == 1) && d >= 0) begin
          r = (m_q[p].size() > 0) ? m_q[p][$] : m_dir[p];
          if (nd == r || nd == (r ^ 2'b10) || (m_q[p].size() == DEPTH && !pop)) e.drop[p] = 1'b1;
          else push = 1'b1;
        end
        if (pop)  m_dir[p] = m_q[p].pop_front();
        if (push) m_q[p].push_back(nd);
      end
      if (kp && k == K_SPACE && m_state != 0) begin
        e.pause = 1'b1;
        m_state = (m_state == 1) ? 2 : 1;
      end
    end
    e.running = (m_state == 1);
    e.dir     = {m_dir[1], m_dir[0]};
    sb.push_back(e);
  endtask

  task automatic drive(input logic kp, input logic [7:0] k, input logic st);
    @(negedge clk);
    if1.key_pressed = kp; if1.key = k; if1.step = st;
    if2.key_pressed = kp; if2.key = k; if2.step = st;
    model_step(kp, k, st);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dir2"},     8'(if2.snake_dir), 8'({DIR_RESET, DIR_RESET}));
    check({tag, "_dir1"},     8'(if1.snake_dir), 8'(DIR_RESET));
    check({tag, "_start"},    8'({if2.start, if1.start}), 8'h0);
    check({tag, "_pause"},    8'({if2.pause, if1.pause}), 8'h0);
    check({tag, "_running"},  8'({if2.running, if1.running}), 8'h0);
    check({tag, "_drop"},     8'({if2.key_drop, if1.key_drop}), 8'h0);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 3)       return K_ENTER;
    else if (r < 7)  return K_SPACE;
    else if (r < 47) return (key_dir_code(0, $urandom_range(0, 3)));
    else if (r < 85) return (key_dir_code(1, $urandom_range(0, 3)));
    else             return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [7:0] key_dir_code(input int p, input int d);
    logic [7:0] c1 [4];
    logic [7:0] c2 [4];
    c1 = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
    c2 = '{8'h75, 8'h74, 8'h72, 8'h6B};
    return (p == 0) ? c1[d] : c2[d];
  endfunction

  // Monitor: compares each cycle's DUT outputs with the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("p2_snake_dir", 8'(if2.snake_dir), 8'(e.dir));
        check("p2_start",     8'(if2.start),     8'(e.start));
        check("p2_pause",     8'(if2.pause),     8'(e.pause));
        check("p2_running",   8'(if2.running),   8'(e.running));
        check("p2_key_drop",  8'(if2.key_drop),  8'(e.drop));
        check("p1_snake_dir", 8'(if1.snake_dir), 8'(e.dir[1:0]));
        check("p1_start",     8'(if1.start),     8'(e.start));
        check("p1_pause",     8'(if1.pause),     8'(e.pause));
        check("p1_running",   8'(if1.running),   8'(e.running));
        check("p1_key_drop",  8'(if1.key_drop),  8'(e.drop[0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    if1.key_pressed = 1'b0; if1.key = 8'h00; if1.step = 1'b0;
    if2.key_pressed = 1'b0; if2.key = 8'h00; if2.step = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle: space, direction keys and steps all ignored.
    drive(1'b1, K_SPACE, 1'b0);
    drive(1'b1, 8'h23,   1'b1);
    drive(1'b0, 8'h00,   1'b1);
    // Start, W without step, then S, A queued and popped in order.
    drive(1'b1, K_ENTER, 1'b1);
    drive(1'b1, 8'h1D,   1'b0);
    drive(1'b0, 8'h00,   1'b1);
    drive(1'b1, K_ENTER, 1'b0);
    drive(1'b1, 8'h1B,   1'b0);
    drive(1'b1, 8'h1C,   1'b0);
    drive(1'b0, 8'h00,   1'b1);
    drive(1'b0, 8'h00,   1'b1);
    // Reversal and duplicate against applied dir 3 (left).
    drive(1'b1, 8'h23,   1'b0);
    drive(1'b1, 8'h1C,   1'b0);
    // Fill to DEPTH with alternating turns, overflow, then overflow with a pop.
    drive(1'b1, 8'h1D,   1'b0);
    drive(1'b1, 8'h23,   1'b0);
    drive(1'b1, 8'h1D,   1'b0);
    drive(1'b1, 8'h23,   1'b0);
    drive(1'b1, 8'h1D,   1'b0);
    drive(1'b1, 8'h1D,   1'b1);
    // Pause blocks keys and steps; resume pops; Enter flushes mid-queue.
    drive(1'b1, K_SPACE, 1'b0);
    drive(1'b1, 8'h1B,   1'b1);
    drive(1'b1, K_SPACE, 1'b0);
    drive(1'b0, 8'h00,   1'b1);
    drive(1'b1, 8'h72,   1'b1);
    drive(1'b1, K_ENTER, 1'b1);
    drive(1'b0, 8'h00,   1'b1);

    for (int i = 0; i < N_CYCLES; i++) begin
      if (i == RST_AT) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 99) < 55, rand_key(),
            $urandom_range(0, 99) < ((i % 800 < 300) ? 8 : 35));
    end

    @(negedge clk);
    if1.key_pressed = 1'b0; if2.key_pressed = 1'b0;
    if1.step = 1'b0;        if2.step = 1'b0;
    @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(sb.size()), 8'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
